// File: rtl/iram_loader_pkg.sv
// rtl/iram_loader_pkg.sv - shared loader constants and FSM state type
package loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int         COUNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/iram_loader_if.sv
// rtl/iram_loader_if.sv - byte stream in, instruction-RAM write port out
interface iram_loader_if #(
  parameter int width       = 16,
  parameter int iaddr_width = 8
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [iaddr_width-1:0] iaddr_write;
  logic [width-1:0]       idata_write;
  logic                   i_write;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, iaddr_write, idata_write, i_write
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, iaddr_write, idata_write, i_write
  );
endinterface

// File: rtl/iram_loader_byte_to_word.sv
// rtl/iram_loader_byte_to_word.sv - LSB-first byte assembler for one instruction word
module byte_to_word #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic [width-1:0] word,
  output logic             word_valid
);
  localparam int BYTES = width / 8;

  logic [width-1:0] shift;
  logic [7:0]       cnt;

  // word already includes the byte arriving this cycle, so the caller can
  // issue the write on the very next clock without stalling the stream
  assign word       = (shift >> 8) | (width'(byte_data) << (width - 8));
  assign word_valid = byte_valid && (cnt == 8'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (byte_valid) begin
      shift <= word;
      cnt   <= word_valid ? 8'd0 : cnt + 8'd1;
    end
  end
endmodule

// File: rtl/iram_loader.sv
// rtl/iram_loader.sv - boot loader: framed byte stream to instruction RAM, gates CPU reset
module iram_loader
  import loader_pkg::*;
#(
  parameter int width       = 16,
  parameter int iaddr_width = 8
) (
  input  logic         clk,
  input  logic         reset,
  iram_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         load_done,
  output logic         load_error
);
  localparam logic [COUNT_WIDTH:0] CAPACITY = (COUNT_WIDTH+1)'(1) << iaddr_width;

  loader_state_t          state, state_n;
  logic [iaddr_width-1:0] addr, addr_n;
  logic [COUNT_WIDTH-1:0] remaining, remaining_n;
  logic [7:0]             sum, sum_n, cnt_lo, cnt_lo_n;
  logic                   rx_ready, rx_ready_n, i_write, i_write_n;
  logic [iaddr_width-1:0] iaddr_q, iaddr_n;
  logic [width-1:0]       idata_q, idata_n;
  logic                   cpu_reset_n, load_done_n, load_error_n;
  logic                   take, clear, byte_valid, word_valid;
  logic [width-1:0]       word;
  logic [COUNT_WIDTH-1:0] count;

  assign take       = bus.rx_valid && rx_ready;
  assign byte_valid = take && (state == S_DATA);
  assign count      = {bus.rx_data, cnt_lo};

  byte_to_word #(.width(width)) u_b2w (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .byte_data  (bus.rx_data),
    .byte_valid (byte_valid),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_n      = state;
    addr_n       = addr;
    remaining_n  = remaining;
    sum_n        = sum;
    cnt_lo_n     = cnt_lo;
    rx_ready_n   = 1'b1;
    i_write_n    = 1'b0;
    iaddr_n      = iaddr_q;
    idata_n      = idata_q;
    cpu_reset_n  = cpu_reset;
    load_done_n  = load_done;
    load_error_n = load_error;
    clear        = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (take && bus.rx_data == LOADER_MAGIC) begin
          state_n      = S_CNT_LO;
          load_done_n  = 1'b0;
          load_error_n = 1'b0;
          cpu_reset_n  = 1'b1;
          addr_n       = '0;
          sum_n        = '0;
          clear        = 1'b1;
        end
      end
      S_CNT_LO: begin
        if (take) begin
          cnt_lo_n = bus.rx_data;
          state_n  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (take) begin
          if (count == '0 || {1'b0, count} > CAPACITY) begin
            state_n      = S_ERROR;
            load_error_n = 1'b1;
          end else begin
            remaining_n = count;
            state_n     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          sum_n = sum + bus.rx_data;
          if (word_valid) begin
            state_n    = S_WRITE;
            i_write_n  = 1'b1;
            iaddr_n    = addr;
            idata_n    = word;
            rx_ready_n = 1'b0;
          end
        end
      end
      S_WRITE: begin
        addr_n      = addr + 1'b1;
        remaining_n = remaining - 1'b1;
        state_n     = (remaining == 1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (take) begin
          if (bus.rx_data == sum) begin
            state_n     = S_DONE;
            cpu_reset_n = 1'b0;
            load_done_n = 1'b1;
          end else begin
            state_n      = S_ERROR;
            load_error_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      sum        <= '0;
      cnt_lo     <= '0;
      rx_ready   <= 1'b1;
      i_write    <= 1'b0;
      iaddr_q    <= '0;
      idata_q    <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      remaining  <= remaining_n;
      sum        <= sum_n;
      cnt_lo     <= cnt_lo_n;
      rx_ready   <= rx_ready_n;
      i_write    <= i_write_n;
      iaddr_q    <= iaddr_n;
      idata_q    <= idata_n;
      cpu_reset  <= cpu_reset_n;
      load_done  <= load_done_n;
      load_error <= load_error_n;
    end
  end

  assign bus.rx_ready    = rx_ready;
  assign bus.i_write     = i_write;
  assign bus.iaddr_write = iaddr_q;
  assign bus.idata_write = idata_q;
endmodule
